// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage between Ex and register-write.
// It accepts one instruction from Ex with a valid/ready handshake. ALU and
// branch results go straight to the write-back bundle. Loads make a one-cycle
// read request and capture the read data on the following cycle. Stores make
// a one-cycle write request and then emit a bundle with no register write.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   ex_ma_valid / ex_ma_ready Ex -> MA handshake
//   ex_ma_pc, ex_ma_alu_result, ex_ma_st_data, ex_ma_ctrl, ex_ma_wr_addr
//                             instruction fields; ctrl = {isLd, isSt, isCall, isWb}
//   dmem_ren, dmem_wen        data-memory read/write strobes (registered)
//   dmem_addr, dmem_wdata     data-memory word address / write data
//   dmem_rdata                read data, valid the cycle after dmem_ren
//   ma_rw_valid / rw_ready    MA -> RW handshake
//   ma_rw_wr_en, ma_rw_wr_addr, ma_rw_wr_data, ma_rw_pc  write-back bundle
module ma_stage #(
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_ma_valid,
  output logic                      ex_ma_ready,
  input  logic [31:0]               ex_ma_pc,
  input  logic [31:0]               ex_ma_alu_result,
  input  logic [31:0]               ex_ma_st_data,
  input  logic [3:0]                ex_ma_ctrl,
  input  logic [3:0]                ex_ma_wr_addr,
  output logic                      dmem_ren,
  output logic                      dmem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]               dmem_wdata,
  input  logic [31:0]               dmem_rdata,
  output logic                      ma_rw_valid,
  input  logic                      rw_ready,
  output logic                      ma_rw_wr_en,
  output logic [3:0]                ma_rw_wr_addr,
  output logic [31:0]               ma_rw_wr_data,
  output logic [31:0]               ma_rw_pc
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned AW     = MEM_ADDR_WIDTH;
  localparam logic [REG_W-1:0] LINK_REG = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WR   = 2'd1,
    LD_REQ  = 2'd2,
    LD_RESP = 2'd3
  } state_t;

  // Instruction fields kept across the multi-cycle load/store sequences.
  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  alu;
    logic             is_ld;
    logic             is_st;
    logic             is_call;
    logic             is_wb;
    logic [REG_W-1:0] wr_addr;
  } instr_t;

  // Write-back bundle presented to the register-write stage.
  typedef struct packed {
    logic             wr_en;
    logic [REG_W-1:0] wr_addr;
    logic [XLEN-1:0]  wr_data;
    logic [XLEN-1:0]  pc;
  } result_t;

  state_t          state_q, state_d;
  instr_t          lat_q, lat_d, in_instr;
  result_t         res_q, res_d;
  logic            valid_q, valid_d;
  logic            ren_q, ren_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            accept;

  // Call return address wins over load data, which wins over the ALU result.
  // Stores never write a register.
  function automatic result_t make_result(input instr_t i, input logic [XLEN-1:0] mem_data);
    result_t r;
    r.wr_en   = i.is_wb & ~i.is_st;
    r.wr_addr = i.is_call ? LINK_REG : i.wr_addr;
    if (i.is_call)    r.wr_data = XLEN'(i.pc + 32'd4);
    else if (i.is_ld) r.wr_data = mem_data;
    else              r.wr_data = i.alu;
    r.pc = i.pc;
    return r;
  endfunction

  always_comb begin
    in_instr.pc      = ex_ma_pc;
    in_instr.alu     = ex_ma_alu_result;
    in_instr.is_ld   = ex_ma_ctrl[3];
    in_instr.is_st   = ex_ma_ctrl[2];
    in_instr.is_call = ex_ma_ctrl[1];
    in_instr.is_wb   = ex_ma_ctrl[0];
    in_instr.wr_addr = ex_ma_wr_addr;
  end

  // Ready only when idle and the output slot is empty or draining this edge.
  assign ex_ma_ready = (state_q == IDLE) && (!valid_q || rw_ready);
  assign accept      = ex_ma_valid && ex_ma_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    res_d   = res_q;
    valid_d = valid_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    // Consumed result leaves the slot; the write enable is qualified by valid.
    if (valid_q && rw_ready) begin
      valid_d     = 1'b0;
      res_d.wr_en = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          lat_d = in_instr;
          if (in_instr.is_ld) begin
            state_d = LD_REQ;
            ren_d   = 1'b1;
            addr_d  = ex_ma_alu_result[AW-1:0];
          end else if (in_instr.is_st) begin
            state_d = ST_WR;
            wen_d   = 1'b1;
            addr_d  = ex_ma_alu_result[AW-1:0];
            wdata_d = ex_ma_st_data;
          end else begin
            // Same-edge replacement of a consumed result: no bubble.
            res_d   = make_result(in_instr, ex_ma_alu_result);
            valid_d = 1'b1;
          end
        end
      end
      LD_REQ: begin
        state_d = LD_RESP;
      end
      LD_RESP: begin
        // Output slot is guaranteed empty here: it drained at the accept edge.
        res_d   = make_result(lat_q, dmem_rdata);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      ST_WR: begin
        res_d   = make_result(lat_q, lat_q.alu);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign dmem_ren      = ren_q;
  assign dmem_wen      = wen_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign ma_rw_valid   = valid_q;
  assign ma_rw_wr_en   = res_q.wr_en;
  assign ma_rw_wr_addr = res_q.wr_addr;
  assign ma_rw_wr_data = res_q.wr_data;
  assign ma_rw_pc      = res_q.pc;

endmodule

// File: tb/tb_ma_stage.sv
// Bench for ma_stage: directed vectors with a result scoreboard, a simple
// word-addressed memory model and cycle-exact directed checks.
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_ma_valid;
  logic        ex_ma_ready;
  logic [31:0] ex_ma_pc;
  logic [31:0] ex_ma_alu_result;
  logic [31:0] ex_ma_st_data;
  logic [3:0]  ex_ma_ctrl;
  logic [3:0]  ex_ma_wr_addr;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        ma_rw_valid;
  logic        rw_ready;
  logic        ma_rw_wr_en;
  logic [3:0]  ma_rw_wr_addr;
  logic [31:0] ma_rw_wr_data;
  logic [31:0] ma_rw_pc;

  typedef struct packed {
    logic        en;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  ma_stage #(.MEM_ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .ex_ma_valid(ex_ma_valid), .ex_ma_ready(ex_ma_ready),
    .ex_ma_pc(ex_ma_pc), .ex_ma_alu_result(ex_ma_alu_result),
    .ex_ma_st_data(ex_ma_st_data), .ex_ma_ctrl(ex_ma_ctrl),
    .ex_ma_wr_addr(ex_ma_wr_addr),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .ma_rw_valid(ma_rw_valid), .rw_ready(rw_ready),
    .ma_rw_wr_en(ma_rw_wr_en), .ma_rw_wr_addr(ma_rw_wr_addr),
    .ma_rw_wr_data(ma_rw_wr_data), .ma_rw_pc(ma_rw_pc)
  );

  // Synchronous memory: read data appears the cycle after the read strobe.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[16] = 32'hDEAD_BEEF;
  end
  always @(posedge clk) begin
    if (dmem_ren) dmem_rdata <= mem[dmem_addr];
    if (dmem_wen) mem[dmem_addr] <= dmem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Result monitor: compares each transferred bundle against the scoreboard.
  always @(negedge clk) begin
    if (dmem_ren) ren_cnt++;
    if (dmem_wen) wen_cnt++;
    if (dmem_ren || dmem_wen) chk("strobes_exclusive", 32'(dmem_ren & dmem_wen), 32'd0);
    if (rst && ma_rw_valid && rw_ready) begin
      exp_t got, exp;
      got = '{en: ma_rw_wr_en, addr: ma_rw_wr_addr, data: ma_rw_wr_data, pc: ma_rw_pc};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got en=%b addr=%h data=%h pc=%h, expected none",
                 got.en, got.addr, got.data, got.pc);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL result: got en=%b addr=%h data=%h pc=%h, expected en=%b addr=%h data=%h pc=%h",
                   got.en, got.addr, got.data, got.pc, exp.en, exp.addr, exp.data, exp.pc);
        end
      end
    end
  end

  // Present one instruction and return #1 after its accept edge.
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] st,
                       input logic [3:0] ctrl, input logic [3:0] wa, input bit has_out,
                       input logic en, input logic [3:0] ea, input logic [31:0] ed);
    int n;
    ex_ma_pc = pc; ex_ma_alu_result = alu; ex_ma_st_data = st;
    ex_ma_ctrl = ctrl; ex_ma_wr_addr = wa; ex_ma_valid = 1'b1;
    if (has_out) sb.push_back('{en: en, addr: ea, data: ed, pc: pc});
    n = 0;
    @(negedge clk);
    while (!ex_ma_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ex_ma_ready) chk("accept_timeout", 32'(ex_ma_ready), 32'd1);
    @(posedge clk);
    #1 ex_ma_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; rw_ready = 1'b1; ex_ma_valid = 1'b0;
    ex_ma_pc = '0; ex_ma_alu_result = '0; ex_ma_st_data = '0;
    ex_ma_ctrl = '0; ex_ma_wr_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ma_rw_valid), 32'd0);
    chk("rst_ren", 32'(dmem_ren), 32'd0);
    chk("rst_wen", 32'(dmem_wen), 32'd0);
    chk("rst_wr_en", 32'(ma_rw_wr_en), 32'd0);
    chk("rst_wr_data", ma_rw_wr_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ex_ma_ready), 32'd1);
    @(posedge clk); #1;

    // ADD: one-cycle latency.
    issue(32'h100, 32'h5, 32'h0, 4'b0001, 4'd3, 1'b1, 1'b1, 4'd3, 32'h5);
    @(negedge clk);
    chk("add_valid", 32'(ma_rw_valid), 32'd1);
    chk("add_wr_en", 32'(ma_rw_wr_en), 32'd1);
    chk("add_wr_addr", 32'(ma_rw_wr_addr), 32'd3);
    chk("add_wr_data", ma_rw_wr_data, 32'h5);
    @(posedge clk); #1;

    // Load from 0x010: read strobe at T+1, result at T+3.
    issue(32'h104, 32'h10, 32'h0, 4'b1001, 4'd5, 1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("ld_ren_t1", 32'(dmem_ren), 32'd1);
    chk("ld_addr_t1", 32'(dmem_addr), 32'h10);
    chk("ld_ready_t1", 32'(ex_ma_ready), 32'd0);
    @(negedge clk);
    chk("ld_ren_t2", 32'(dmem_ren), 32'd0);
    chk("ld_ready_t2", 32'(ex_ma_ready), 32'd0);
    chk("ld_valid_t2", 32'(ma_rw_valid), 32'd0);
    @(negedge clk);
    chk("ld_valid_t3", 32'(ma_rw_valid), 32'd1);
    chk("ld_data_t3", ma_rw_wr_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Store to 0x0FF: write strobe at T+1, bundle without write at T+2.
    issue(32'h200, 32'hFF, 32'h1234_5678, 4'b0100, 4'd7, 1'b1, 1'b0, 4'd7, 32'hFF);
    @(negedge clk);
    chk("st_wen_t1", 32'(dmem_wen), 32'd1);
    chk("st_ren_t1", 32'(dmem_ren), 32'd0);
    chk("st_addr_t1", 32'(dmem_addr), 32'hFF);
    chk("st_wdata_t1", dmem_wdata, 32'h1234_5678);
    @(negedge clk);
    chk("st_wen_t2", 32'(dmem_wen), 32'd0);
    chk("st_valid_t2", 32'(ma_rw_valid), 32'd1);
    chk("st_wr_en_t2", 32'(ma_rw_wr_en), 32'd0);
    @(posedge clk); #1;

    // Load from 0x10FF truncates to 0x0FF and sees the stored word.
    issue(32'h204, 32'h10FF, 32'h0, 4'b1001, 4'd6, 1'b1, 1'b1, 4'd6, 32'h1234_5678);
    @(negedge clk);
    chk("wrap_addr", 32'(dmem_addr), 32'hFF);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    // Call at the top of the address space: link = PC+4 wraps to 0.
    issue(32'hFFFF_FFFC, 32'hABC, 32'h0, 4'b0011, 4'd2, 1'b1, 1'b1, 4'hF, 32'h0);
    @(negedge clk);
    chk("call_wr_addr", 32'(ma_rw_wr_addr), 32'hF);
    chk("call_wr_data", ma_rw_wr_data, 32'h0);
    @(posedge clk); #1;

    // Back-to-back ALU ops.
    issue(32'h300, 32'hA, 32'h0, 4'b0001, 4'd8, 1'b1, 1'b1, 4'd8, 32'hA);
    issue(32'h304, 32'hB, 32'h0, 4'b0000, 4'd9, 1'b1, 1'b0, 4'd9, 32'hB);
    issue(32'h308, 32'hC, 32'h0, 4'b0001, 4'd10, 1'b1, 1'b1, 4'd10, 32'hC);
    @(negedge clk);
    chk("b2b_last_data", ma_rw_wr_data, 32'hC);
    @(posedge clk); #1;

    // Back-pressure: result A held, B waits, then both transfer in order.
    rw_ready = 1'b0;
    issue(32'h400, 32'h11, 32'h0, 4'b0001, 4'd1, 1'b1, 1'b1, 4'd1, 32'h11);
    ex_ma_pc = 32'h404; ex_ma_alu_result = 32'h22; ex_ma_ctrl = 4'b0001;
    ex_ma_wr_addr = 4'd2; ex_ma_valid = 1'b1;
    sb.push_back('{en: 1'b1, addr: 4'd2, data: 32'h22, pc: 32'h404});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ma_rw_valid), 32'd1);
      chk("hold_data", ma_rw_wr_data, 32'h11);
      chk("hold_addr", 32'(ma_rw_wr_addr), 32'd1);
      chk("hold_ready", 32'(ex_ma_ready), 32'd0);
    end
    @(posedge clk); #1 rw_ready = 1'b1;
    @(posedge clk); #1 ex_ma_valid = 1'b0;
    @(negedge clk);
    chk("replace_valid", 32'(ma_rw_valid), 32'd1);
    chk("replace_data", ma_rw_wr_data, 32'h22);
    @(posedge clk); #1;

    // Reset during LD_REQ abandons the load.
    issue(32'h500, 32'h20, 32'h0, 4'b1001, 4'd4, 1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    chk("rstld_ren_before", 32'(dmem_ren), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rstld_ren", 32'(dmem_ren), 32'd0);
    chk("rstld_valid", 32'(ma_rw_valid), 32'd0);
    chk("rstld_idle_ready", 32'(ex_ma_ready), 32'd1);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rstld_no_result", 32'(ma_rw_valid), 32'd0);
      chk("rstld_no_ren", 32'(dmem_ren), 32'd0);
    end

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("ren_pulses", 32'(ren_cnt), 32'd3);
    chk("wen_pulses", 32'(wen_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
MA_STAGE -- requirements
Module: ma_stage

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 12, the data-memory word-address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ex_ma_valid, input, 1, Ex stage presents a valid instruction.
REQ-005 SHALL have port ex_ma_ready, output, 1, this stage accepts the Ex instruction this cycle.
REQ-006 SHALL have port ex_ma_pc, input, 32, PC of the instruction.
REQ-007 SHALL have port ex_ma_alu_result, input, 32, ALU result, which is also the memory address for ld/st.
REQ-008 SHALL have port ex_ma_st_data, input, 32, store data (rd contents).
REQ-009 SHALL have port ex_ma_ctrl, input, 4, {isLd, isSt, isCall, isWb}, with bit 3 = isLd.
REQ-010 SHALL have port ex_ma_wr_addr, input, 4, destination register.
REQ-011 SHALL have ports dmem_ren and dmem_wen, output, 1 each: read strobe and write strobe.
REQ-012 SHALL have port dmem_addr, output, MEM_ADDR_WIDTH, word address.
REQ-013 SHALL have port dmem_wdata, output, 32, write data; SHALL have port dmem_rdata, input, 32, read data, valid the cycle after dmem_ren.
REQ-014 SHALL have port ma_rw_valid, output, 1, result valid to the register-write stage.
REQ-015 SHALL have port rw_ready, input, 1, register-write stage consumes the result.
REQ-016 SHALL have ports ma_rw_wr_en, ma_rw_wr_addr, ma_rw_wr_data and ma_rw_pc, output, 1/4/32/32: write-back bundle.

Function
REQ-017 SHALL accept an instruction on a rising edge where ex_ma_valid and ex_ma_ready are both 1; accepted fields are latched.
REQ-018 SHALL assert ex_ma_ready = (state==IDLE) and (ma_rw_valid==0 or rw_ready==1).
REQ-019 SHALL implement the FSM states IDLE, ST_WR, LD_REQ and LD_RESP.
REQ-020 SHALL transition IDLE to LD_REQ on accepting a load, IDLE to ST_WR on accepting a store, and remain in IDLE on accepting any other instruction.
REQ-021 SHALL, in LD_REQ, drive dmem_ren=1 for exactly one cycle with dmem_addr=latched alu_result[MEM_ADDR_WIDTH-1:0], then go to LD_RESP.
REQ-022 SHALL, in LD_RESP, capture dmem_rdata, set ma_rw_valid=1 on the next edge, and return to IDLE.
REQ-023 SHALL, in ST_WR, drive dmem_wen=1 for exactly one cycle with the latched address and st_data, set ma_rw_valid=1 on the next edge (ma_rw_wr_en=0), and return to IDLE.
REQ-024 SHALL give ma_rw_valid latencies after the accept edge of 1 cycle for ALU/branch ops, 2 for stores and 3 for loads.
REQ-025 SHALL select ma_rw_wr_data as PC+4 (mod 2^32) if isCall, else the load data if isLd, else alu_result; isCall takes priority over isLd.
REQ-026 SHALL set ma_rw_wr_en=isWb, qualified by ma_rw_valid, and ma_rw_wr_addr=4'hF if isCall, else ex_ma_wr_addr.
REQ-027 SHALL hold ma_rw_valid and the whole bundle stable while rw_ready=0; ma_rw_valid clears on an edge with rw_ready=1 unless a new result loads simultaneously.
REQ-028 SHALL, when IDLE with a valid output and rw_ready=1 and ex_ma_valid=1, replace the output and accept the new instruction on the same edge with no bubble for ALU ops.
REQ-029 SHALL keep dmem_ren and dmem_wen at 0 in all states other than LD_REQ and ST_WR, respectively.
REQ-030 SHALL never assert dmem_ren and dmem_wen in the same cycle.
REQ-031 SHALL wrap addresses above 2^MEM_ADDR_WIDTH-1 via truncation, with no error signalled.

Reset
REQ-032 SHALL, while rst=0, asynchronously force state=IDLE, ma_rw_valid=0, ma_rw_wr_en=0, all latched data and bundle outputs to 0, and dmem_ren=dmem_wen=0.
REQ-033 SHALL, when reset asserts mid-load or mid-store, abandon the operation with no strobe after the reset edge and no result emitted.
REQ-034 SHALL take ex_ma_ready=1 in the first cycle after rst deasserts.

Verification
REQ-035 SHALL cover an ADD with alu_result=0x0000_0005, wr_addr=3, isWb=1 -> next cycle ma_rw_valid=1, wr_en=1, wr_addr=3, wr_data=0x5.
REQ-036 SHALL cover a load at addr 0x010 with memory[0x010]=0xDEAD_BEEF -> dmem_ren pulses once at T+1 with addr 0x010, and at T+3 wr_data=0xDEAD_BEEF with ex_ma_ready=0 during T+1..T+2.
REQ-037 SHALL cover a store with addr 0x0FF and data 0x1234_5678 -> a single dmem_wen pulse at T+1, then ma_rw_valid=1 with wr_en=0 at T+2.
REQ-038 SHALL cover a call with pc=0xFFFF_FFFC -> wr_addr=0xF, wr_data=0x0000_0000 (wrap-around).
REQ-039 SHALL cover rw_ready held 0 for 3 cycles after a valid result -> bundle held constant, ex_ma_ready=0, and no instruction lost or duplicated once rw_ready=1.
REQ-040 SHALL cover rst pulsed low during LD_REQ -> dmem_ren drops immediately, ma_rw_valid=0, and the FSM is IDLE.
